// File: rtl/final_flush_controller.sv
`timescale 1ns/1ps
// final_flush_controller
// Sequences the end-of-frame flush of the arithmetic encoder. A flush request
// captures the encoder's final cnt/low and presents them to the combinational
// final-bits generator. The generator's word-count flag and words are then
// sampled, and 0, 1 or 2 final words go out over a valid/ready handshake.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   in_flush_valid/_ready       flush request handshake (in_cnt/in_low valid)
//   in_cnt, in_low              final encoder state
//   gen_cnt, gen_low            registered state driven to the generator
//   gen_flag, gen_bit_1/_2      generator results (word count, words)
//   out_valid/_ready, out_word  final word stream, out_last marks last word
//   out_done                    one-cycle pulse when a flush completes
//   out_flag_err                one-cycle pulse when gen_flag==2'b11 was seen
module final_flush_controller #(
  parameter int unsigned OUTPUT_BITSTREAM_WIDTH = 16,
  parameter int unsigned D_SIZE                 = 5,
  parameter int unsigned LOW_WIDTH              = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_flush_valid,
  output logic                              in_flush_ready,
  input  logic [D_SIZE-1:0]                 in_cnt,
  input  logic [LOW_WIDTH-1:0]              in_low,
  output logic [D_SIZE-1:0]                 gen_cnt,
  output logic [LOW_WIDTH-1:0]              gen_low,
  input  logic [1:0]                        gen_flag,
  input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] gen_bit_1,
  input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] gen_bit_2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_word,
  output logic                              out_last,
  output logic                              out_done,
  output logic                              out_flag_err
);

  localparam int unsigned OW = OUTPUT_BITSTREAM_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_EMIT1 = 3'd2;
  localparam logic [2:0] S_EMIT2 = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [D_SIZE-1:0]    gen_cnt_q, gen_cnt_d;
  logic [LOW_WIDTH-1:0] gen_low_q, gen_low_d;
  logic [OW-1:0]        w2_q, w2_d;
  logic                 last_q, last_d;
  logic [OW-1:0]        out_word_q, out_word_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 out_done_q, out_done_d;
  logic                 flag_err_q, flag_err_d;
  logic                 ready_q, ready_d;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gen_cnt_q   <= '0;
      gen_low_q   <= '0;
      w2_q        <= '0;
      last_q      <= 1'b0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_done_q  <= 1'b0;
      flag_err_q  <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      gen_cnt_q   <= gen_cnt_d;
      gen_low_q   <= gen_low_d;
      w2_q        <= w2_d;
      last_q      <= last_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_done_q  <= out_done_d;
      flag_err_q  <= flag_err_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    gen_cnt_d  = gen_cnt_q;
    gen_low_d  = gen_low_q;
    w2_d       = w2_q;
    last_d     = last_q;
    out_word_d = out_word_q;
    flag_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ready_q is always high in IDLE, so valid alone accepts
        if (in_flush_valid) begin
          gen_cnt_d = in_cnt;
          gen_low_d = in_low;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        // Generator has seen the captured cnt/low for a full cycle
        w2_d = gen_bit_2;
        case (gen_flag)
          2'b01: begin
            last_d     = 1'b1;
            out_word_d = gen_bit_1;
            state_d    = S_EMIT1;
          end
          2'b10: begin
            last_d     = 1'b0;
            out_word_d = gen_bit_1;
            state_d    = S_EMIT1;
          end
          2'b11: begin
            flag_err_d = 1'b1;
            state_d    = S_DONE;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_EMIT1: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            out_word_d = w2_q;
            state_d    = S_EMIT2;
          end
        end
      end
      S_EMIT2: begin
        if (out_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs registered as a function of the state being entered
    out_valid_d = (state_d == S_EMIT1) || (state_d == S_EMIT2);
    out_last_d  = ((state_d == S_EMIT1) && last_d) || (state_d == S_EMIT2);
    out_done_d  = (state_d == S_DONE);
    ready_d     = (state_d == S_IDLE);
  end

  assign in_flush_ready = ready_q;
  assign gen_cnt        = gen_cnt_q;
  assign gen_low        = gen_low_q;
  assign out_valid      = out_valid_q;
  assign out_word       = out_word_q;
  assign out_last       = out_last_q;
  assign out_done       = out_done_q;
  assign out_flag_err   = flag_err_q;

endmodule

// File: tb/tb_final_flush_controller.sv
`timescale 1ns/1ps
// Directed bench for final_flush_controller with a stubbed final-bits generator.
module tb_final_flush_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_flush_valid;
  logic        in_flush_ready;
  logic [4:0]  in_cnt;
  logic [23:0] in_low;
  logic [4:0]  gen_cnt;
  logic [23:0] gen_low;
  logic [1:0]  gen_flag;
  logic [15:0] gen_bit_1;
  logic [15:0] gen_bit_2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_last;
  logic        out_done;
  logic        out_flag_err;
  logic        force_err;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  final_flush_controller #(
    .OUTPUT_BITSTREAM_WIDTH(16),
    .D_SIZE(5),
    .LOW_WIDTH(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_flush_valid(in_flush_valid),
    .in_flush_ready(in_flush_ready),
    .in_cnt(in_cnt),
    .in_low(in_low),
    .gen_cnt(gen_cnt),
    .gen_low(gen_low),
    .gen_flag(gen_flag),
    .gen_bit_1(gen_bit_1),
    .gen_bit_2(gen_bit_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word(out_word),
    .out_last(out_last),
    .out_done(out_done),
    .out_flag_err(out_flag_err)
  );

  // Stub generator: cnt<8 -> one word (0x0080|low[15:0]);
  // cnt<16 -> two words (low[23:8], 0x0080); otherwise no words.
  always_comb begin
    gen_flag  = 2'b00;
    gen_bit_1 = 16'h0000;
    gen_bit_2 = 16'h0000;
    if (force_err) begin
      gen_flag  = 2'b11;
      gen_bit_1 = 16'hDEAD;
      gen_bit_2 = 16'hBEEF;
    end else if (gen_cnt < 5'd8) begin
      gen_flag  = 2'b01;
      gen_bit_1 = 16'h0080 | gen_low[15:0];
    end else if (gen_cnt < 5'd16) begin
      gen_flag  = 2'b10;
      gen_bit_1 = gen_low[23:8];
      gen_bit_2 = 16'h0080;
    end else begin
      gen_bit_1 = 16'hFFFF;
    end
  end

  // Advance one clock; sample point is 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++;
    if (in_flush_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_flush_ready); end
    vectors++;
    if ({out_valid, out_last, out_done, out_flag_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, out_last, out_done, out_flag_err});
    end
    vectors++;
    if ({out_word, gen_cnt, gen_low} !== 45'd0) begin
      errors++; $display("FAIL reset_data word=%h cnt=%0d low=%h exp all 0", out_word, gen_cnt, gen_low);
    end
  endtask

  task automatic test_one_word();
    out_ready = 1'b1;
    in_flush_valid = 1'b1; in_cnt = 5'd0; in_low = 24'd0;
    step();
    in_flush_valid = 1'b0;
    vectors++;
    if (in_flush_ready !== 1'b0 || out_valid !== 1'b0 || gen_cnt !== 5'd0 || gen_low !== 24'd0) begin
      errors++; $display("FAIL one_eval ready=%b valid=%b cnt=%0d low=%h exp 0 0 0 0", in_flush_ready, out_valid, gen_cnt, gen_low);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 16'h0080 || out_last !== 1'b1) begin
      errors++; $display("FAIL one_word valid=%b word=%h last=%b exp 1 0080 1", out_valid, out_word, out_last);
    end
    step();
    vectors++;
    if (out_done !== 1'b1 || out_valid !== 1'b0 || in_flush_ready !== 1'b0) begin
      errors++; $display("FAIL one_done done=%b valid=%b ready=%b exp 1 0 0", out_done, out_valid, in_flush_ready);
    end
    step();
    vectors++;
    if (out_done !== 1'b0 || in_flush_ready !== 1'b1) begin
      errors++; $display("FAIL one_idle done=%b ready=%b exp 0 1", out_done, in_flush_ready);
    end
  endtask

  task automatic test_two_words();
    out_ready = 1'b1;
    in_flush_valid = 1'b1; in_cnt = 5'd8; in_low = 24'd0;
    step();
    in_flush_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 16'h0000 || out_last !== 1'b0) begin
      errors++; $display("FAIL two_w1 valid=%b word=%h last=%b exp 1 0000 0", out_valid, out_word, out_last);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 16'h0080 || out_last !== 1'b1) begin
      errors++; $display("FAIL two_w2 valid=%b word=%h last=%b exp 1 0080 1", out_valid, out_word, out_last);
    end
    step();
    vectors++;
    if (out_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL two_done done=%b valid=%b exp 1 0", out_done, out_valid);
    end
    step();
  endtask

  // Zero-word flush, with a request held during DONE that must wait for IDLE
  task automatic test_zero_words_done_req();
    out_ready = 1'b1;
    in_flush_valid = 1'b1; in_cnt = 5'd22; in_low = 24'h000123;
    step();
    in_flush_valid = 1'b0;
    vectors++;
    if (out_done !== 1'b0 || gen_cnt !== 5'd22) begin
      errors++; $display("FAIL zero_eval done=%b cnt=%0d exp 0 22", out_done, gen_cnt);
    end
    step();
    vectors++;
    if (out_done !== 1'b1 || out_valid !== 1'b0 || out_flag_err !== 1'b0) begin
      errors++; $display("FAIL zero_done done=%b valid=%b err=%b exp 1 0 0", out_done, out_valid, out_flag_err);
    end
    in_flush_valid = 1'b1; in_cnt = 5'd3; in_low = 24'h000004;
    step();
    vectors++;
    if (in_flush_ready !== 1'b1 || gen_cnt !== 5'd22 || out_done !== 1'b0) begin
      errors++; $display("FAIL done_noaccept ready=%b cnt=%0d done=%b exp 1 22 0", in_flush_ready, gen_cnt, out_done);
    end
    step();
    in_flush_valid = 1'b0;
    vectors++;
    if (gen_cnt !== 5'd3 || gen_low !== 24'h000004 || in_flush_ready !== 1'b0) begin
      errors++; $display("FAIL idle_accept cnt=%0d low=%h ready=%b exp 3 000004 0", gen_cnt, gen_low, in_flush_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 16'h0084 || out_last !== 1'b1) begin
      errors++; $display("FAIL late_word valid=%b word=%h last=%b exp 1 0084 1", out_valid, out_word, out_last);
    end
    step();
    step();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_flush_valid = 1'b1; in_cnt = 5'd9; in_low = 24'hABCD00;
    step();
    in_flush_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_word !== 16'hABCD || out_last !== 1'b0 || in_flush_ready !== 1'b0
          || gen_cnt !== 5'd9 || gen_low !== 24'hABCD00) begin
        errors++; $display("FAIL stall_w1[%0d] valid=%b word=%h last=%b ready=%b cnt=%0d exp 1 abcd 0 0 9",
                           i, out_valid, out_word, out_last, in_flush_ready, gen_cnt);
      end
      if (i == 3) out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_word !== 16'h0080 || out_last !== 1'b1 || in_flush_ready !== 1'b0) begin
        errors++; $display("FAIL stall_w2[%0d] valid=%b word=%h last=%b ready=%b exp 1 0080 1 0",
                           i, out_valid, out_word, out_last, in_flush_ready);
      end
      if (i == 3) out_ready = 1'b1;
      step();
    end
    vectors++;
    if (out_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_done done=%b valid=%b exp 1 0", out_done, out_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_flush_valid = 1'b1; in_cnt = 5'd8; in_low = 24'h123400;
    step();
    in_flush_valid = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 16'h0080 || out_last !== 1'b1) begin
      errors++; $display("FAIL mid_emit2 valid=%b word=%h last=%b exp 1 0080 1", out_valid, out_word, out_last);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_flush_ready !== 1'b1 || out_done !== 1'b0 || gen_cnt !== 5'd0) begin
      errors++; $display("FAIL mid_reset valid=%b ready=%b done=%b cnt=%0d exp 0 1 0 0", out_valid, in_flush_ready, out_done, gen_cnt);
    end
    step();
    vectors++;
    if (out_done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_nodone done=%b valid=%b exp 0 0", out_done, out_valid);
    end
    out_ready = 1'b1;
    in_flush_valid = 1'b1; in_cnt = 5'd1; in_low = 24'h000100;
    step();
    in_flush_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 16'h0180 || out_last !== 1'b1) begin
      errors++; $display("FAIL mid_new_word valid=%b word=%h last=%b exp 1 0180 1", out_valid, out_word, out_last);
    end
    step();
    vectors++;
    if (out_done !== 1'b1) begin errors++; $display("FAIL mid_new_done done=%b exp 1", out_done); end
    step();
  endtask

  task automatic test_flag_err();
    out_ready = 1'b1;
    force_err = 1'b1;
    in_flush_valid = 1'b1; in_cnt = 5'd0; in_low = 24'd0;
    step();
    in_flush_valid = 1'b0;
    vectors++;
    if (out_flag_err !== 1'b0) begin errors++; $display("FAIL err_early err=%b exp 0", out_flag_err); end
    step();
    vectors++;
    if (out_flag_err !== 1'b1 || out_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL err_pulse err=%b done=%b valid=%b exp 1 1 0", out_flag_err, out_done, out_valid);
    end
    step();
    vectors++;
    if (out_flag_err !== 1'b0 || out_done !== 1'b0 || in_flush_ready !== 1'b1) begin
      errors++; $display("FAIL err_after err=%b done=%b ready=%b exp 0 0 1", out_flag_err, out_done, in_flush_ready);
    end
    force_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_flush_valid = 1'b0;
    in_cnt = 5'd0;
    in_low = 24'd0;
    out_ready = 1'b0;
    force_err = 1'b0;
    #1;
    test_reset();
    test_one_word();
    test_two_words();
    test_zero_words_done_req();
    test_stall();
    test_reset_mid();
    test_flag_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
